instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the MIPS control unit. Holds the PC, requests instruction words from instruction memory over a ready handshake, and presents the held instruction and its opcode field to decode/control.
- Consumes the control unit's branch/jump decisions (brn, bne, jmp) plus the ALU zero flag to compute the next PC when decode accepts the instruction.
- Supports an external flush/redirect that can cancel an in-flight fetch.

---
 rtl/instr_fetch_unit.sv | 186 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage feeding the MIPS control unit: owns the PC, fetches over a ready handshake,
// resolves branch/jump on decode accept. Optional perf counters under FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic        instr_valid,
    input  logic        dec_ready,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic        brn,
    input  logic        bne,
    input  logic        jmp,
    input  logic        zero,
    input  logic [31:0] br_imm,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_timeout
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] retired_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] W_MAX = WCW'(MAX_WAIT);
    localparam logic [WCW-1:0] W_ONE = WCW'(1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_VALID,
        S_DROP
    } state_t;

    state_t         r_state;
    logic [31:0]    r_pc;
    logic [31:0]    r_addr;
    logic [31:0]    r_instr;
    logic           r_valid;
    logic           r_req;
    logic           r_timeout;
    logic [WCW-1:0] r_wait;

    logic [31:0] w_pc4;
    logic [31:0] w_flush_tgt;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_next_pc;
    logic        w_taken;
    logic        w_stall;

    assign w_pc4       = r_pc + 32'd4;
    assign w_flush_tgt = flush_pc & 32'hFFFF_FFFC;
    assign w_br_tgt    = w_pc4 + (br_imm << 2);
    assign w_jmp_tgt   = {w_pc4[31:28], r_instr[25:0], 2'b00};
    assign w_taken     = (brn & zero) | (bne & ~zero);
    assign w_next_pc   = jmp ? w_jmp_tgt : (w_taken ? w_br_tgt : w_pc4);
    assign w_stall     = r_req & ~imem_ready;

    // r_addr is kept apart from r_pc so S_DROP can hold the old request address
    // while r_pc already carries the redirect target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
            r_addr  <= RESET_PC;
            r_instr <= 32'h0;
            r_valid <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                    if (flush) begin
                        r_pc   <= w_flush_tgt;
                        r_addr <= w_flush_tgt;
                    end else begin
                        r_addr <= r_pc;
                    end
                end
                S_FETCH: begin
                    if (flush) begin
                        r_pc <= w_flush_tgt;
                        if (imem_ready) begin
                            r_addr <= w_flush_tgt;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end else if (imem_ready) begin
                        r_instr <= imem_rdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (flush) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_flush_tgt;
                        r_addr  <= w_flush_tgt;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end else if (dec_ready) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_next_pc;
                        r_addr  <= w_next_pc;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                S_DROP: begin
                    if (flush) begin
                        r_pc <= w_flush_tgt;
                    end else if (imem_ready) begin
                        r_addr  <= r_pc;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                    r_valid <= 1'b0;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Saturating wait counter; the request itself keeps going after the timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (flush || !w_stall) begin
                r_wait <= '0;
            end else if (r_wait != W_MAX) begin
                r_wait    <= r_wait + W_ONE;
                r_timeout <= ((r_wait + W_ONE) == W_MAX);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired_cnt <= 32'h0;
            r_stall_cnt   <= 32'h0;
        end else begin
            if (r_valid && dec_ready && !flush) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (w_stall) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign stall_cnt   = r_stall_cnt;
`endif

    assign imem_req     = r_req;
    assign imem_addr    = r_addr;
    assign instr        = r_instr;
    assign opcode       = r_instr[31:26];
    assign instr_valid  = r_valid;
    assign pc           = r_pc;
    assign link_addr    = w_pc4;
    assign imem_timeout = r_timeout;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: boot fetch, branches, jump, flush/drop, stall timeout,
// async reset mid-request, and perf counters when FETCH_PERF_CNT_EN is defined.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        dec_ready;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        brn, bne, jmp, zero;
    logic [31:0] br_imm;
    logic        flush;
    logic [31:0] flush_pc;
    logic        imem_timeout;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .dec_ready(dec_ready), .pc(pc), .link_addr(link_addr),
        .brn(brn), .bne(bne), .jmp(jmp), .zero(zero), .br_imm(br_imm),
        .flush(flush), .flush_pc(flush_pc), .imem_timeout(imem_timeout)
`ifdef FETCH_PERF_CNT_EN
        , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle fetch completion while in S_FETCH.
    task automatic fetch(input logic [31:0] data);
        imem_ready = 1'b1;
        imem_rdata = data;
        tick();
        imem_ready = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        flush    = 1'b1;
        flush_pc = tgt;
        tick();
        flush    = 1'b0;
    endtask

    initial begin
        int pulses;
        int pulse_at;
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; dec_ready = 1'b0;
        brn = 1'b0; bne = 1'b0; jmp = 1'b0; zero = 1'b0; br_imm = 32'h0;
        flush = 1'b0; flush_pc = 32'h0;
        tick(); tick();
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_timeout", 32'(imem_timeout), 32'h0);

        // boot fetch
        rst = 1'b0;
        tick();
        chk("boot_req", 32'(imem_req), 32'h1);
        chk("boot_addr", imem_addr, 32'h0);
        chk("boot_valid", 32'(instr_valid), 32'h0);
        fetch(32'h8C08_0004);
        chk("lw_valid", 32'(instr_valid), 32'h1);
        chk("lw_instr", instr, 32'h8C08_0004);
        chk("lw_opcode", 32'(opcode), 32'h23);
        chk("lw_pc", pc, 32'h0);
        chk("lw_link", link_addr, 32'h4);
        chk("lw_req", 32'(imem_req), 32'h0);

        // flush beats dec_ready; low address bits masked
        dec_ready = 1'b1;
        redirect(32'h13);
        dec_ready = 1'b0;
        chk("fl_valid", 32'(instr_valid), 32'h0);
        chk("fl_addr", imem_addr, 32'h10);
        chk("fl_req", 32'(imem_req), 32'h1);

        // beq taken backwards: 0x14 + (-2<<2) = 0x0C
        fetch(32'h1000_FFFE);
        chk("beq_pc", pc, 32'h10);
        brn = 1'b1; zero = 1'b1; br_imm = 32'hFFFF_FFFE; dec_ready = 1'b1;
        tick();
        brn = 1'b0; zero = 1'b0; dec_ready = 1'b0;
        chk("beq_t_addr", imem_addr, 32'h0C);
        chk("beq_t_valid", 32'(instr_valid), 32'h0);
        fetch(32'h0000_0000);
        chk("pc_0c", pc, 32'h0C);

        // beq not taken: 0x14
        redirect(32'h10);
        fetch(32'h1000_FFFE);
        brn = 1'b1; zero = 1'b0; br_imm = 32'hFFFF_FFFE; dec_ready = 1'b1;
        tick();
        brn = 1'b0; dec_ready = 1'b0;
        chk("beq_nt_addr", imem_addr, 32'h14);

        // bne taken: 0x18 + 12 = 0x24
        fetch(32'h1400_0003);
        bne = 1'b1; zero = 1'b0; br_imm = 32'h3; dec_ready = 1'b1;
        tick();
        bne = 1'b0; dec_ready = 1'b0;
        chk("bne_addr", imem_addr, 32'h24);

        // jump wins over a simultaneous taken beq
        fetch(32'h0000_0000);
        redirect(32'h4000_0008);
        fetch(32'h0800_0100);
        chk("j_pc", pc, 32'h4000_0008);
        chk("j_link", link_addr, 32'h4000_000C);
        chk("j_opcode", 32'(opcode), 32'h02);
        jmp = 1'b1; brn = 1'b1; zero = 1'b1; br_imm = 32'h5; dec_ready = 1'b1;
        tick();
        jmp = 1'b0; brn = 1'b0; zero = 1'b0; dec_ready = 1'b0;
        chk("j_addr", imem_addr, 32'h4000_0400);

        // flush while the request is pending: old address held, data discarded
        redirect(32'h200);
        chk("drop_req", 32'(imem_req), 32'h1);
        chk("drop_addr0", imem_addr, 32'h4000_0400);
        tick(); tick();
        chk("drop_addr2", imem_addr, 32'h4000_0400);
        fetch(32'hDEAD_BEEF);
        chk("drop_valid", 32'(instr_valid), 32'h0);
        chk("drop_instr", instr, 32'h0800_0100);
        chk("drop_newaddr", imem_addr, 32'h200);
        chk("drop_newreq", 32'(imem_req), 32'h1);
        chk("drop_timeout", 32'(imem_timeout), 32'h0);

        // decode stall: held state stable, no request
        fetch(32'h2008_0005);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_instr", instr, 32'h2008_0005);
            chk("hold_pc", pc, 32'h200);
            chk("hold_valid", 32'(instr_valid), 32'h1);
            chk("hold_req", 32'(imem_req), 32'h0);
        end
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("seq_addr", imem_addr, 32'h204);

        // withheld imem_ready: single timeout pulse after 4 wait cycles
        pulses = 0; pulse_at = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (imem_timeout) begin
                pulses++;
                pulse_at = i;
            end
        end
        chk("to_pulses", 32'(pulses), 32'h1);
        chk("to_at", 32'(pulse_at), 32'h4);
        chk("to_req_kept", 32'(imem_req), 32'h1);
        chk("to_addr_kept", imem_addr, 32'h204);
        fetch(32'h0000_0000);
        chk("to_done_valid", 32'(instr_valid), 32'h1);
        chk("to_done_to", 32'(imem_timeout), 32'h0);

        // async reset mid-request, late ready ignored
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("pre_rst_req", 32'(imem_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'h0);
        chk("async_pc", pc, 32'h0);
        imem_ready = 1'b1; imem_rdata = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        tick();
        imem_ready = 1'b0;
        chk("late_valid", 32'(instr_valid), 32'h0);
        chk("late_instr", instr, 32'h0);
        chk("late_req", 32'(imem_req), 32'h1);
        chk("late_addr", imem_addr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("perf_ret0", retired_cnt, 32'h0);
        chk("perf_stall0", stall_cnt, 32'h0);
        for (int n = 0; n < 3; n++) begin
            tick(); tick();
            fetch(32'h0000_0000);
            dec_ready = 1'b1;
            tick();
            dec_ready = 1'b0;
        end
        chk("perf_ret", retired_cnt, 32'h3);
        chk("perf_stall", stall_cnt, 32'h6);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
